// File: rtl/fetch_branch_stage_pkg.sv
// Shared fetch/branch constants and helpers, also used by the hazard unit and ID stage.
package fetch_branch_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'hE1A0_0000;
  localparam logic [XLEN-1:0] DEF_PC_AHEAD  = 32'd8;
  localparam logic [XLEN-1:0] PC_INCR       = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  // Saturating increment for the redirect counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/fetch_branch_stage_if_id_reg.sv
// IF/ID pipeline register: holds on ~en, loads a NOP bubble on flush.
module fetch_branch_stage_if_id_reg
  import fetch_branch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  if_id_t q;
  if_id_t d;

  // Flushed slot keeps the fetch PC but carries a bubble.
  always_comb begin
    d = '{instr: instr_d, pc: pc_d, valid: 1'b1};
    if (flush) begin
      d.instr = NOP_INSTR;
      d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else if (en) begin
      q <= d;
    end
  end

  assign instr = q.instr;
  assign pc    = q.pc;
  assign valid = q.valid;

endmodule

// File: rtl/fetch_branch_stage.sv
// Fetch stage: PC register, next-PC mux, branch target adder and IF/ID register.
module fetch_branch_stage
  import fetch_branch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter logic [XLEN-1:0] PC_AHEAD  = DEF_PC_AHEAD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  ext_offset,
  input  logic [XLEN-1:0]  imem_data,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic             if_id_valid,
  output logic [23:0]      imm24,
  output logic [XLEN-1:0]  branch_target,
  output logic [CNT_W-1:0] branch_count
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            redirect;

  assign imem_addr     = pc;
  assign imm24         = if_id_instr[23:0];
  assign branch_target = if_id_pc + PC_AHEAD + ext_offset;

  // A bubble in IF/ID can never redirect, and a stalled cycle never accepts one.
  assign redirect = branch_taken & if_id_valid & ~stall;

  always_comb begin
    pc_next = pc + PC_INCR;
    if (redirect) begin
      pc_next = branch_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count <= '0;
    end else if (redirect) begin
      branch_count <= sat_inc(branch_count);
    end
  end

  fetch_branch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .en      (~stall),
    .flush   (redirect),
    .instr_d (imem_data),
    .pc_d    (pc),
    .instr   (if_id_instr),
    .pc      (if_id_pc),
    .valid   (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_branch_stage.sv
// Directed, table-driven bench for fetch_branch_stage plus a wrap-around instance.
module tb_fetch_branch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] ext_offset;

  logic [31:0] imem_data, imem_addr, if_id_instr, if_id_pc, branch_target;
  logic        if_id_valid;
  logic [23:0] imm24;
  logic [15:0] branch_count;

  logic [31:0] w_imem_data, w_imem_addr, w_if_id_instr, w_if_id_pc, w_branch_target;
  logic        w_if_id_valid;
  logic [23:0] w_imm24;
  logic [15:0] w_branch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    instr_at = a ^ 32'h5A5A_0000;
  endfunction

  assign imem_data   = instr_at(imem_addr);
  assign w_imem_data = instr_at(w_imem_addr);

  fetch_branch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .ext_offset(ext_offset), .imem_data(imem_data), .imem_addr(imem_addr),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .imm24(imm24), .branch_target(branch_target), .branch_count(branch_count)
  );

  fetch_branch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .ext_offset(ext_offset), .imem_data(w_imem_data), .imem_addr(w_imem_addr),
    .if_id_instr(w_if_id_instr), .if_id_pc(w_if_id_pc), .if_id_valid(w_if_id_valid),
    .imm24(w_imm24), .branch_target(w_branch_target), .branch_count(w_branch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        bt;
    logic [31:0] off;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] o,
                              input logic ct, input logic [31:0] t, input logic [31:0] a,
                              input logic [31:0] ins, input logic [31:0] p,
                              input logic v, input logic [15:0] c);
    mk = '{stall: s, bt: b, off: o, chk_tgt: ct, tgt: t, addr: a,
           instr: ins, pc: p, valid: v, cnt: c};
  endfunction

  vec_t vecs[16];

  initial begin
    logic [31:0] ei;
    // Expected state after each rising edge, with the inputs applied before it.
    vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,   32'h04,  instr_at(32'h00),  32'h00,  1, 0);
    vecs[1]  = mk(0, 0, 32'h0,         0, 32'h0,   32'h08,  instr_at(32'h04),  32'h04,  1, 0);
    vecs[2]  = mk(0, 0, 32'h0,         0, 32'h0,   32'h0C,  instr_at(32'h08),  32'h08,  1, 0);
    vecs[3]  = mk(0, 0, 32'h0,         0, 32'h0,   32'h10,  instr_at(32'h0C),  32'h0C,  1, 0);
    vecs[4]  = mk(0, 0, 32'h0,         0, 32'h0,   32'h14,  instr_at(32'h10),  32'h10,  1, 0);
    vecs[5]  = mk(0, 1, 32'h20,        1, 32'h38,  32'h38,  NOP,               32'h14,  0, 1);
    vecs[6]  = mk(0, 1, 32'h20,        0, 32'h0,   32'h3C,  instr_at(32'h38),  32'h38,  1, 1);
    vecs[7]  = mk(0, 0, 32'h0,         0, 32'h0,   32'h40,  instr_at(32'h3C),  32'h3C,  1, 1);
    vecs[8]  = mk(0, 0, 32'h0,         0, 32'h0,   32'h44,  instr_at(32'h40),  32'h40,  1, 1);
    vecs[9]  = mk(0, 1, 32'hFFFF_FFE8, 1, 32'h30,  32'h30,  NOP,               32'h44,  0, 2);
    vecs[10] = mk(0, 0, 32'h0,         0, 32'h0,   32'h34,  instr_at(32'h30),  32'h30,  1, 2);
    vecs[11] = mk(1, 1, 32'h100,       1, 32'h138, 32'h34,  instr_at(32'h30),  32'h30,  1, 2);
    vecs[12] = mk(1, 1, 32'h100,       0, 32'h0,   32'h34,  instr_at(32'h30),  32'h30,  1, 2);
    vecs[13] = mk(1, 1, 32'h100,       0, 32'h0,   32'h34,  instr_at(32'h30),  32'h30,  1, 2);
    vecs[14] = mk(0, 1, 32'h100,       1, 32'h138, 32'h138, NOP,               32'h34,  0, 3);
    vecs[15] = mk(0, 0, 32'h0,         0, 32'h0,   32'h13C, instr_at(32'h138), 32'h138, 1, 3);

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; ext_offset = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc",    if_id_pc, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_cnt",   32'(branch_count), 32'h0);
    chk("rst_imm24", 32'(imm24), 32'h00A0_0000);
    chk("rst_tgt",   branch_target, 32'h8);
    chk("rst_waddr", w_imem_addr, 32'hFFFF_FFF8);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall; branch_taken = vecs[i].bt; ext_offset = vecs[i].off;
      #1;
      if (vecs[i].chk_tgt) chk($sformatf("v%0d_tgt", i), branch_target, vecs[i].tgt);
      @(posedge clk); #1;
      ei = vecs[i].instr;
      chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_instr", i), if_id_instr, ei);
      chk($sformatf("v%0d_pc", i),    if_id_pc, vecs[i].pc);
      chk($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_cnt", i),   32'(branch_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_imm24", i), 32'(imm24), 32'(ei[23:0]));
    end

    // Redirect, then async reset between edges.
    stall = 1'b0; branch_taken = 1'b1; ext_offset = 32'h8;
    @(posedge clk); #1;
    chk("mr_redir_addr", imem_addr, 32'h148);
    chk("mr_redir_cnt",  32'(branch_count), 32'h4);
    branch_taken = 1'b0; ext_offset = 32'h0;
    #2; reset = 1'b1; #1;
    chk("mr_addr",  imem_addr, 32'h0);
    chk("mr_instr", if_id_instr, NOP);
    chk("mr_pc",    if_id_pc, 32'h0);
    chk("mr_valid", 32'(if_id_valid), 32'h0);
    chk("mr_cnt",   32'(branch_count), 32'h0);
    @(posedge clk); #1;
    chk("mr_hold_addr", imem_addr, 32'h0);
    chk("mr_waddr",     w_imem_addr, 32'hFFFF_FFF8);
    reset = 1'b0; #1;
    chk("mr_pre_valid", 32'(if_id_valid), 32'h0);
    @(posedge clk); #1;
    chk("mr1_addr",  imem_addr, 32'h4);
    chk("mr1_instr", if_id_instr, instr_at(32'h0));
    chk("mr1_pc",    if_id_pc, 32'h0);
    chk("mr1_valid", 32'(if_id_valid), 32'h1);
    chk("w1_addr",   w_imem_addr, 32'hFFFF_FFFC);
    chk("w1_pc",     w_if_id_pc, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("w2_addr",   w_imem_addr, 32'h0);
    chk("w2_pc",     w_if_id_pc, 32'hFFFF_FFFC);
    chk("w2_instr",  w_if_id_instr, instr_at(32'hFFFF_FFFC));
    chk("w2_tgt",    w_branch_target, 32'h4);
    @(posedge clk); #1;
    chk("w3_addr",   w_imem_addr, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
